// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP test-pattern transmitter:
// frame-phase states, pattern encodings and the RGB565 colour-bar palette.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS      = 2'd0,
        PAT_RAMP      = 2'd1,
        PAT_CHECKER   = 2'd2,
        PAT_FRAME_TAG = 2'd3
    } pattern_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// RGB565 pixel generator: combinational patterns plus a per-line bar counter
// that tracks the colour-bar index without dividing x.
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] frame_cnt,
    input  pattern_t    sel,
    input  logic        line_start,
    output logic [15:0] pix
);
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar_idx_q, bar_idx;
    logic [15:0] bar_cnt_q, bar_cnt;
    logic        x_lsb_q;
    logic        unused_bits;

    // x advances by one every two byte clocks, so a toggle of its LSB marks a new pixel.
    always_comb begin
        bar_idx = bar_idx_q;
        bar_cnt = bar_cnt_q;
        if (line_start) begin
            bar_idx = '0;
            bar_cnt = '0;
        end else if (x[0] != x_lsb_q) begin
            if (bar_cnt_q == 16'(BAR_W - 1)) begin
                bar_idx = bar_idx_q + 3'd1;
                bar_cnt = '0;
            end else begin
                bar_cnt = bar_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx_q <= '0;
            bar_cnt_q <= '0;
            x_lsb_q   <= 1'b0;
        end else begin
            bar_idx_q <= bar_idx;
            bar_cnt_q <= bar_cnt;
            x_lsb_q   <= x[0];
        end
    end

    always_comb begin
        pix = 16'h0000;
        case (sel)
            PAT_BARS:      pix = bar_colour(bar_idx);
            PAT_RAMP:      pix = x;
            PAT_CHECKER:   pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            PAT_FRAME_TAG: pix = {frame_cnt[4:0], 6'h00, ~frame_cnt[4:0]};
            default:       pix = 16'h0000;
        endcase
    end

    assign unused_bits = ^{y[15:4], y[2:0], frame_cnt[15:5]};

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV5640-style DVP source: frame-phase FSM, column/line counters and registered
// vsync/href/data outputs driven from the next-cycle position.
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 360,
    parameter int H_BLANK  = 64,
    parameter int VS_LINES = 4,
    parameter int V_BPORCH = 8,
    parameter int V_FPORCH = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W     = $clog2(LINE_CLKS + 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_CLKS - 1);
    localparam logic [COL_W-1:0] HREF_CLKS = COL_W'(2 * H_ACTIVE);

    function automatic logic [15:0] last_line(input state_t s);
        case (s)
            ST_VSYNC:  return 16'(VS_LINES - 1);
            ST_VBP:    return 16'(V_BPORCH - 1);
            ST_ACTIVE: return 16'(V_ACTIVE - 1);
            ST_VFP:    return 16'(V_FPORCH - 1);
            default:   return 16'h0000;
        endcase
    endfunction

    function automatic state_t succ(input state_t s);
        case (s)
            ST_VSYNC:  return ST_VBP;
            ST_VBP:    return ST_ACTIVE;
            ST_ACTIVE: return ST_VFP;
            default:   return ST_IDLE;
        endcase
    endfunction

    // First non-empty phase at or after s; ST_IDLE here means the frame is over.
    function automatic state_t first_from(input state_t s);
        case (s)
            ST_VSYNC:  return (VS_LINES > 0) ? ST_VSYNC : (V_BPORCH > 0) ? ST_VBP : ST_ACTIVE;
            ST_VBP:    return (V_BPORCH > 0) ? ST_VBP : ST_ACTIVE;
            ST_ACTIVE: return ST_ACTIVE;
            ST_VFP:    return (V_FPORCH > 0) ? ST_VFP : ST_IDLE;
            default:   return ST_IDLE;
        endcase
    endfunction

    state_t           state, state_n, after;
    logic [COL_W-1:0] col, col_n;
    logic [15:0]      line, line_n;
    logic             frame_end, frame_start;
    pattern_t         sel_q, sel_n;
    logic [15:0]      frame_cnt_n;
    logic [15:0]      x_n, pix;
    logic             vsync_n, href_n;
    logic [7:0]       data_n;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        col_n     = col;
        line_n    = line;
        frame_end = 1'b0;
        after     = ST_IDLE;
        if (state == ST_IDLE) begin
            if (enable) begin
                state_n = first_from(ST_VSYNC);
                col_n   = '0;
                line_n  = '0;
            end
        end else if (col != COL_LAST) begin
            col_n = col + COL_W'(1);
        end else begin
            col_n = '0;
            if (line != last_line(state)) begin
                line_n = line + 16'd1;
            end else begin
                line_n = '0;
                after  = first_from(succ(state));
                if (after == ST_IDLE) begin
                    frame_end = 1'b1;
                    state_n   = enable ? first_from(ST_VSYNC) : ST_IDLE;
                end else begin
                    state_n = after;
                end
            end
        end
        frame_start = enable && ((state == ST_IDLE) || frame_end);
    end

    assign sel_n       = frame_start ? pattern_t'(pattern_sel) : sel_q;
    assign frame_cnt_n = frame_cnt + {15'd0, frame_end};
    assign x_n         = 16'(col_n >> 1);

    dvp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .x          (x_n),
        .y          (line_n),
        .frame_cnt  (frame_cnt_n),
        .sel        (sel_n),
        .line_start (col_n == '0),
        .pix        (pix)
    );

    // Outputs are registered from the next position so they line up with the state register.
    assign vsync_n = (state_n == ST_VSYNC);
    assign href_n  = (state_n == ST_ACTIVE) && (col_n < HREF_CLKS);
    assign data_n  = href_n ? (col_n[0] ? pix[7:0] : pix[15:8]) : 8'h00;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            col        <= '0;
            line       <= '0;
            sel_q      <= PAT_BARS;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
        end else begin
            state      <= state_n;
            col        <= col_n;
            line       <= line_n;
            sel_q      <= sel_n;
            cam_vsync  <= vsync_n;
            cam_href   <= href_n;
            cam_data   <= data_n;
            frame_done <= frame_end;
            frame_cnt  <= frame_cnt_n;
        end
    end

endmodule
